// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches floor calls, sweeps in one direction
// while calls remain ahead, opens the door at called floors, and supports an emergency hold.
module elevator_ctrl #(
  parameter int NUM_FLOORS  = 4,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  emerg_in,
  input  logic                  emerg_clr,
  output logic [3:0]            Disp_1,
  output logic [3:0]            Disp_2,
  output logic                  emerg_out,
  output logic                  door_open,
  output logic                  moving,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MW = $clog2(MOVE_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR      = 2'd2,
    EMERGENCY = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [MW-1:0]         move_cnt_r, move_cnt_s;
  logic [DW-1:0]         door_cnt_r, door_cnt_s;
  logic [NUM_FLOORS-1:0] pend_s;
  logic [3:0]            floor_s, target_s, step_floor_s;
  logic                  dir_s, at_limit_s;
  logic [4:0]            near_fwd_s, near_bwd_s;

  function automatic logic bit_at(input logic [NUM_FLOORS-1:0] vec, input logic [3:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) b = (idx == 4'(i)) ? vec[i] : b;
    return b;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_FLOORS-1:0] v;
    for (int i = 0; i < NUM_FLOORS; i++) v[i] = (idx == 4'(i));
    return v;
  endfunction

  // True when any call lies strictly beyond idx in the given direction.
  function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] vec, input logic [3:0] idx,
                                     input logic up);
    logic a;
    a = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      a = a | (vec[i] & (up ? (4'(i) > idx) : (4'(i) < idx)));
    return a;
  endfunction

  // Nearest call at or beyond idx in the given direction; bit 4 flags a hit.
  function automatic logic [4:0] nearest(input logic [NUM_FLOORS-1:0] vec, input logic [3:0] idx,
                                         input logic up);
    logic [4:0] r;
    r = 5'd0;
    if (up) begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--)
        r = (vec[i] && (4'(i) >= idx)) ? {1'b1, 4'(i)} : r;
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++)
        r = (vec[i] && (4'(i) <= idx)) ? {1'b1, 4'(i)} : r;
    end
    return r;
  endfunction

  assign step_floor_s = dir_up ? (Disp_1 + 4'd1) : (Disp_1 - 4'd1);
  assign at_limit_s   = dir_up ? (Disp_1 == 4'(NUM_FLOORS - 1)) : (Disp_1 == 4'd0);

  // Next-state, call latching and target selection.
  always_comb begin
    state_s    = state_r;
    pend_s     = pending;
    floor_s    = Disp_1;
    dir_s      = dir_up;
    move_cnt_s = move_cnt_r;
    door_cnt_s = door_cnt_r;
    target_s   = Disp_1;
    if (emerg_in) begin
      state_s    = EMERGENCY;
      pend_s     = '0;
      move_cnt_s = '0;
      door_cnt_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          pend_s = pending | call_req;
          if (bit_at(pending, Disp_1)) begin
            state_s    = DOOR;
            pend_s     = (pending | call_req) & ~onehot(Disp_1);
            door_cnt_s = '0;
          end else if (any_ahead(pending, Disp_1, dir_up)) begin
            state_s    = MOVING;
            move_cnt_s = '0;
          end else if (any_ahead(pending, Disp_1, !dir_up)) begin
            state_s    = MOVING;
            dir_s      = !dir_up;
            move_cnt_s = '0;
          end else begin
            state_s = IDLE;
          end
        end
        MOVING: begin
          pend_s = pending | call_req;
          if (move_cnt_r != MW'(MOVE_CYCLES - 1)) begin
            move_cnt_s = move_cnt_r + MW'(1);
          end else if (at_limit_s) begin
            state_s    = IDLE;
            move_cnt_s = '0;
          end else begin
            move_cnt_s = '0;
            floor_s    = step_floor_s;
            if (bit_at(pending, step_floor_s)) begin
              state_s    = DOOR;
              pend_s     = (pending | call_req) & ~onehot(step_floor_s);
              door_cnt_s = '0;
            end else if (any_ahead(pending, step_floor_s, dir_up)) begin
              state_s = MOVING;
            end else begin
              state_s = IDLE;
            end
          end
        end
        DOOR: begin
          // A call at the open floor holds the door instead of latching.
          pend_s = pending | (call_req & ~onehot(Disp_1));
          if (bit_at(call_req, Disp_1)) begin
            door_cnt_s = '0;
          end else if (door_cnt_r == DW'(DOOR_CYCLES - 1)) begin
            state_s    = IDLE;
            door_cnt_s = '0;
          end else begin
            door_cnt_s = door_cnt_r + DW'(1);
          end
        end
        EMERGENCY: begin
          pend_s = '0;
          if (emerg_clr) state_s = IDLE;
          else           state_s = EMERGENCY;
        end
        default: begin
          state_s    = IDLE;
          pend_s     = '0;
          move_cnt_s = '0;
          door_cnt_s = '0;
        end
      endcase
    end
    near_fwd_s = nearest(pend_s, floor_s, dir_s);
    near_bwd_s = nearest(pend_s, floor_s, !dir_s);
    if (near_fwd_s[4])      target_s = near_fwd_s[3:0];
    else if (near_bwd_s[4]) target_s = near_bwd_s[3:0];
    else                    target_s = floor_s;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      move_cnt_r <= '0;
      door_cnt_r <= '0;
      Disp_1     <= 4'd0;
      Disp_2     <= 4'd0;
      dir_up     <= 1'b1;
      pending    <= '0;
      emerg_out  <= 1'b0;
      door_open  <= 1'b0;
      moving     <= 1'b0;
    end else begin
      state_r    <= state_s;
      move_cnt_r <= move_cnt_s;
      door_cnt_r <= door_cnt_s;
      Disp_1     <= floor_s;
      Disp_2     <= target_s;
      dir_up     <= dir_s;
      pending    <= pend_s;
      emerg_out  <= (state_s == EMERGENCY);
      door_open  <= (state_s == DOOR);
      moving     <= (state_s == MOVING);
    end
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors, legal range 2..16.
REQ-002 Parameter MOVE_CYCLES, default 4, clock cycles to travel one floor, legal range >=1.
REQ-003 Parameter DOOR_CYCLES, default 3, clock cycles door remains open per stop, legal range >=1.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 call_req  input  NUM_FLOORS  per-floor call buttons, level-sampled every cycle.
REQ-007 emerg_in  input  1  emergency request, level.
REQ-008 emerg_clr  input  1  emergency release, level.
REQ-009 Disp_1  output  4  current floor, registered.
REQ-010 Disp_2  output  4  next target floor, registered.
REQ-011 emerg_out  output  1  high while in EMERGENCY.
REQ-012 door_open  output  1  high while in DOOR.
REQ-013 moving  output  1  high while in MOVING.
REQ-014 dir_up  output  1  travel direction, 1 = up.
REQ-015 pending  output  NUM_FLOORS  latched outstanding calls.

Function
REQ-016 States SHALL be IDLE, MOVING, DOOR, EMERGENCY; all outputs registered.
REQ-017 Latching: each edge outside EMERGENCY, pending |= call_req, except that the current-floor bit is not set while in DOOR.
REQ-018 A call is visible in pending one cycle after sampling; IDLE acts on the registered pending, so a response appears no earlier than the second edge after sampling.
REQ-019 IDLE: current-floor bit set -> DOOR, clear that bit.
REQ-020 IDLE: otherwise, pending in dir_up direction -> MOVING, same direction.
REQ-021 IDLE: otherwise, pending only in opposite direction -> flip dir_up, MOVING.
REQ-022 IDLE: pending == 0 -> remain in IDLE.
REQ-023 MOVING: a travel counter counts MOVE_CYCLES edges, then Disp_1 steps by +/-1 and the counter restarts at 0.
REQ-024 On each arrival, a set pending bit at the new floor -> DOOR and clear that bit; otherwise continue MOVING.
REQ-025 Disp_1 SHALL never leave 0..NUM_FLOORS-1, because MOVING only starts or continues toward a pending floor.
REQ-026 DOOR: door_open=1 for DOOR_CYCLES cycles, then IDLE.
REQ-027 A current-floor call in DOOR restarts the door counter.
REQ-028 Disp_2 is updated every cycle to the nearest pending floor in the dir_up direction; if none, the nearest pending floor in the opposite direction; if none, Disp_1.
REQ-029 emerg_in=1 in any state SHALL cause EMERGENCY at the next edge.
REQ-030 On EMERGENCY entry: emerg_out=1, moving=0, door_open=0, pending cleared, travel counter cleared, Disp_1 held at the last reached floor, Disp_2 <= Disp_1.
REQ-031 In EMERGENCY, call_req is ignored.
REQ-032 Exit EMERGENCY to IDLE only when emerg_clr=1 and emerg_in=0; Disp_1 and dir_up are preserved and emerg_out=0 at the next edge.
REQ-033 Priority: reset > emerg_in > emerg_clr > normal operation.
REQ-034 Simultaneous emerg_in and emerg_clr SHALL result in EMERGENCY.
REQ-035 emerg_clr outside EMERGENCY SHALL have no effect.

Reset
REQ-036 reset=0 at an edge SHALL give: IDLE, Disp_1=0, Disp_2=0, pending=0, dir_up=1, emerg_out=0, door_open=0, moving=0, all counters 0.
REQ-037 Reset mid-MOVING or mid-DOOR SHALL discard partial travel and return to floor 0 without a move sequence.
REQ-038 call_req is not latched during any cycle with reset=0.

Verification (NUM_FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=3)
REQ-039 Reset, then call_req=4'b1000 for 1 cycle -> moving=1, Disp_2=3; Disp_1 steps 1,2,3 at 4-cycle intervals; door_open=1 for 3 cycles; IDLE; pending=0.
REQ-040 At floor 0, calls 4'b1100 then 4'b0010 mid-travel before floor 1 arrival -> stops at 1, then 2, then 3, in order; each stop has 3 door cycles.
REQ-041 At floor 3 going up, call 4'b0001 -> dir_up flips to 0, travels to floor 0.
REQ-042 emerg_in pulse mid-travel between floors 1 and 2 -> emerg_out=1, moving=0, Disp_1=1, Disp_2=1, pending=0; calls ignored; emerg_clr -> IDLE at floor 1.
REQ-043 emerg_in and emerg_clr both high -> stays EMERGENCY; emerg_clr with emerg_in low -> IDLE next edge.
REQ-044 Current-floor call during DOOR -> door_open extended to 3 cycles after the last call; reset=0 mid-door -> all outputs at reset values next edge.
